// File: rtl/gray_bbox_detect_pkg.sv
// Shared video definitions for the gray bounding-box detector.
//   PIX_W           : video bus width (24-bit, gray in the top byte)
//   VS_ACTIVE_HIGH  : default vsync active level
//   bbox_state_e    : frame-tracking FSM encoding
//   gray_of()       : extracts the gray byte from a video word
package gray_bbox_detect_pkg;

  localparam int PIX_W = 24;
  localparam bit VS_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_LATCH   = 2'd2
  } bbox_state_e;

  function automatic logic [7:0] gray_of(input logic [PIX_W-1:0] pix);
    return pix[PIX_W-1 -: 8];
  endfunction

endpackage

// File: rtl/gray_bbox_detect_vid_xy_counter.sv
// Pixel coordinate generator.
//   clk, rst_n : pixel clock, async active-low reset
//   de_i       : data enable
//   vs_i       : vertical sync (active level VS_POL)
//   x_o, y_o   : coordinates of the pixel presented this cycle
//   fs_o       : frame-start strobe (vs_i entering its active level)
// x counts pixels within a line (first pixel is 0), y counts completed lines
// since frame start. Both saturate at all-ones.
module vid_xy_counter
  import gray_bbox_detect_pkg::*;
#(
  parameter int CW     = 12,
  parameter bit VS_POL = VS_ACTIVE_HIGH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de_i,
  input  logic          vs_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          fs_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          vs_q, de_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          de_fall;

  // vs_q resets to the active level so a vsync already in progress at
  // reset release is not mistaken for a frame start.
  assign fs_o    = (vs_i == VS_POL) && (vs_q != VS_POL);
  assign de_fall = de_q && !de_i;

  always_comb begin
    x_d = '0;
    if (de_i) x_d = (x_q == CNT_MAX) ? x_q : x_q + CW'(1);

    y_d = y_q;
    if (fs_o)         y_d = '0;
    else if (de_fall) y_d = (y_q == CNT_MAX) ? y_q : y_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/gray_bbox_detect.sv
// Gray-level binarizer with per-frame bounding-box detection.
//   clk, rst_n               : pixel clock, async active-low reset
//   din, de_in, hs_in, vs_in : input video (gray in din[23:16])
//   thresh                   : hit threshold, sampled at each frame start
//   bin_out, de/hs/vs_out    : binarized video, 1-cycle latency
//   box_x/y_min/max, pix_cnt : bounding box / hit count of last full frame
//   box_valid                : latched pix_cnt >= MIN_PIX
//   box_update               : one-cycle pulse when box outputs refresh
module gray_bbox_detect
  import gray_bbox_detect_pkg::*;
#(
  parameter int CW      = 12,
  parameter int MIN_PIX = 16,
  parameter bit VS_POL  = VS_ACTIVE_HIGH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  din,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [7:0]        thresh,
  output logic [PIX_W-1:0]  bin_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [CW-1:0]     box_x_min,
  output logic [CW-1:0]     box_x_max,
  output logic [CW-1:0]     box_y_min,
  output logic [CW-1:0]     box_y_max,
  output logic [2*CW-1:0]   pix_cnt,
  output logic              box_valid,
  output logic              box_update
);

  localparam logic [2*CW-1:0] CNT_MAX = '1;
  localparam logic [2*CW-1:0] MIN_CNT = (2*CW)'(MIN_PIX);

  logic [CW-1:0] x, y;
  logic          fs;
  logic          hit;

  bbox_state_e   state_q;
  logic [7:0]    thr_q;

  // frame accumulators
  logic [CW-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
  logic [2*CW-1:0] cnt_q;
  logic [CW-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
  logic [2*CW-1:0] cnt_d;

  // registered outputs
  logic [PIX_W-1:0] bin_q;
  logic             de_q, hs_q, vs_q;
  logic [CW-1:0]    bxmin_q, bxmax_q, bymin_q, bymax_q;
  logic [2*CW-1:0]  bcnt_q;
  logic             bvalid_q, bupd_q;

  vid_xy_counter #(
    .CW     (CW),
    .VS_POL (VS_POL)
  ) u_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .de_i  (de_in),
    .vs_i  (vs_in),
    .x_o   (x),
    .y_o   (y),
    .fs_o  (fs)
  );

  assign hit = de_in && (gray_of(din) >= thr_q);

  // Next accumulator value. In LATCH the old frame is being copied out, so
  // this cycle's pixel starts the new frame from the initial values.
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (state_q == ST_LATCH) begin
      xmin_d = '1;
      xmax_d = '0;
      ymin_d = '1;
      ymax_d = '0;
      cnt_d  = '0;
    end
    if (hit) begin
      if (x < xmin_d) xmin_d = x;
      if (x > xmax_d) xmax_d = x;
      if (y < ymin_d) ymin_d = y;
      if (y > ymax_d) ymax_d = y;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + (2*CW)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT_VS;
      thr_q    <= '0;
      xmin_q   <= '1;
      xmax_q   <= '0;
      ymin_q   <= '1;
      ymax_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      bxmin_q  <= '0;
      bxmax_q  <= '0;
      bymin_q  <= '0;
      bymax_q  <= '0;
      bcnt_q   <= '0;
      bvalid_q <= 1'b0;
      bupd_q   <= 1'b0;
    end else begin
      bin_q  <= hit ? '1 : '0;
      de_q   <= de_in;
      hs_q   <= hs_in;
      vs_q   <= vs_in;
      bupd_q <= 1'b0;
      if (fs) thr_q <= thresh;

      case (state_q)
        // A frame-start pixel belongs to neither frame, so the accumulators
        // are only reset (WAIT_VS) or held (ACCUM) on that cycle.
        ST_WAIT_VS: begin
          if (fs) begin
            state_q <= ST_ACCUM;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            cnt_q   <= '0;
          end
        end
        ST_ACCUM: begin
          if (fs) begin
            state_q <= ST_LATCH;
          end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
          end
        end
        ST_LATCH: begin
          bxmin_q  <= xmin_q;
          bxmax_q  <= xmax_q;
          bymin_q  <= ymin_q;
          bymax_q  <= ymax_q;
          bcnt_q   <= cnt_q;
          bvalid_q <= (cnt_q >= MIN_CNT);
          bupd_q   <= 1'b1;
          xmin_q   <= xmin_d;
          xmax_q   <= xmax_d;
          ymin_q   <= ymin_d;
          ymax_q   <= ymax_d;
          cnt_q    <= cnt_d;
          state_q  <= ST_ACCUM;
        end
        default: state_q <= ST_WAIT_VS;
      endcase
    end
  end

  assign bin_out    = bin_q;
  assign de_out     = de_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign box_x_min  = bxmin_q;
  assign box_x_max  = bxmax_q;
  assign box_y_min  = bymin_q;
  assign box_y_max  = bymax_q;
  assign pix_cnt    = bcnt_q;
  assign box_valid  = bvalid_q;
  assign box_update = bupd_q;

endmodule

// File: tb/tb_gray_bbox_detect.sv
module tb_gray_bbox_detect;

  typedef struct packed {
    logic [11:0] xmin, xmax, ymin, ymax;
    logic [23:0] cnt;
    logic        valid;
  } box_t;

  typedef struct packed {
    logic        de, hs, vs;
    logic [23:0] bin;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] din = '0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [7:0]  thresh = '0;
  logic [23:0] bin_out;
  logic        de_out, hs_out, vs_out;
  logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [23:0] pix_cnt;
  logic        box_valid, box_update;

  gray_bbox_detect #(.CW(12), .MIN_PIX(16), .VS_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .de_in(de_in), .hs_in(hs_in),
    .vs_in(vs_in), .thresh(thresh), .bin_out(bin_out), .de_out(de_out),
    .hs_out(hs_out), .vs_out(vs_out), .box_x_min(box_x_min),
    .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .pix_cnt(pix_cnt), .box_valid(box_valid), .box_update(box_update)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0;
  px_t  px_q[$];
  box_t box_q[$];
  box_t cur = '0;

  // reference model state
  logic [7:0] img [0:7][0:63];
  logic [7:0] thr_m = '0;
  logic       vs_prev_m = 1'b0;
  bit         armed_m = 0;
  box_t       pend = '0;

  function automatic box_t act_box();
    box_t b;
    b.xmin = box_x_min; b.xmax = box_x_max;
    b.ymin = box_y_min; b.ymax = box_y_max;
    b.cnt = pix_cnt; b.valid = box_valid;
    return b;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    px_t  ep, ap;
    box_t ab;
    if (px_q.size() > 0) begin
      ep = px_q.pop_front();
      ap = {de_out, hs_out, vs_out, bin_out};
      n_vec++;
      if (ap !== ep) begin
        n_err++;
        $display("FAIL video: got %h expected %h", ap, ep);
      end
    end
    if (!rst_n) cur = '0;
    else begin
      if (box_update === 1'b1) begin
        n_vec++;
        if (box_q.size() == 0) begin
          n_err++;
          $display("FAIL box_update: got unexpected pulse, expected none");
        end else cur = box_q.pop_front();
      end
      ab = act_box();
      n_vec++;
      if (ab !== cur) begin
        n_err++;
        $display("FAIL box: got %h expected %h", ab, cur);
      end
    end
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] g);
    px_t e;
    @(negedge clk);
    de_in = de; hs_in = hs; vs_in = vs; din = {g, 16'($urandom)};
    e.de = de; e.hs = hs; e.vs = vs;
    e.bin = (de && g >= thr_m) ? 24'hFFFFFF : 24'h000000;
    if (vs && !vs_prev_m) thr_m = thresh;
    vs_prev_m = vs;
    @(posedge clk);
    px_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    #1;
    n_vec++;
    if ({bin_out, de_out, hs_out, vs_out, act_box(), box_update} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got bin=%h box=%h upd=%b expected all zero",
               bin_out, act_box(), box_update);
    end
    box_q.delete();
    armed_m = 0; vs_prev_m = 1'b0; thr_m = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  // One frame of W x H taken from img. tight: line 0 starts right after the
  // frame-start cycle. lead: a stray pixel sits on the frame-start cycle; its
  // line end counts as a line, so rows land at y = row + 1.
  task automatic emit_frame(input int W, input int H, input logic [7:0] thr,
                            input bit tight, input bit lead, input int rst_row,
                            input int thr_row, input logic [7:0] thr_new);
    box_t b;
    int   off;
    thresh = thr;
    if (armed_m) box_q.push_back(pend);
    drive(lead, 1'b0, 1'b1, lead ? 8'hFF : 8'h00);
    armed_m = 1;
    if (!tight) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == rst_row && c == 5) begin
          do_reset();
          return;
        end
        if (r == thr_row && c == 0) thresh = thr_new;
        drive(1'b1, 1'b0, 1'b0, img[r][c]);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    off = lead ? 1 : 0;
    b = '0; b.xmin = 12'hFFF; b.ymin = 12'hFFF;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r][c] >= thr) begin
          if (c < b.xmin) b.xmin = 12'(c);
          if (c > b.xmax) b.xmax = 12'(c);
          if (r + off < b.ymin) b.ymin = 12'(r + off);
          if (r + off > b.ymax) b.ymax = 12'(r + off);
          b.cnt++;
        end
    b.valid = (b.cnt >= 16);
    pend = b;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 64; c++) img[r][c] = v;
  endtask

  task automatic pattern_032();
    fill(8'h10);
    for (int r = 3; r <= 5; r++) for (int c = 10; c <= 20; c++) img[r][c] = 8'h80;
  endtask

  initial begin
    #3;
    n_vec++;
    if ({bin_out, de_out, hs_out, vs_out, act_box(), box_update} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got bin=%h box=%h expected all zero", bin_out, act_box());
    end
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);

    // first frame after reset: no update at its start
    pattern_032();
    emit_frame(64, 8, 8'h80, 0, 0, -1, -1, 8'h00);   // box (10,20,3,5) cnt 33
    pattern_032();
    emit_frame(64, 8, 8'h81, 0, 0, -1, -1, 8'h00);   // zero hits
    fill(8'h00); img[1][2] = 8'h90; img[4][40] = 8'hA0; img[6][7] = 8'hFF;
    emit_frame(64, 8, 8'h80, 1, 0, -1, -1, 8'h00);   // 3 hits, not valid
    fill(8'h00); img[0][0] = 8'hFF; img[7][63] = 8'hFF;
    emit_frame(64, 8, 8'h80, 1, 0, -1, -1, 8'h00);   // corners, LATCH-cycle pixel
    pattern_032();
    emit_frame(64, 8, 8'h80, 0, 0, -1, 2, 8'h00);    // threshold change mid-frame
    emit_frame(64, 8, 8'h00, 0, 0, -1, -1, 8'h00);   // new threshold: all hit
    fill(8'h20);
    emit_frame(16, 4, 8'h10, 0, 1, -1, -1, 8'h00);   // stray pixel on frame start

    for (int f = 0; f < 10; f++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 64; c++)
          img[r][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      emit_frame($urandom_range(4, 64), $urandom_range(1, 8), 8'($urandom_range(64, 192)),
                 (f % 3) == 0, (f % 3) == 1, -1, (f % 4 == 2) ? 1 : -1, 8'($urandom));
    end

    // reset mid-frame: partial frame dropped, update only on the second start
    pattern_032();
    emit_frame(64, 8, 8'h80, 0, 0, 4, -1, 8'h00);
    emit_frame(64, 8, 8'h80, 0, 0, -1, -1, 8'h00);
    fill(8'h00); img[2][9] = 8'hC0;
    emit_frame(32, 4, 8'h80, 0, 0, -1, -1, 8'h00);

    // final frame start flushes the last box
    thresh = 8'h00;
    if (armed_m) box_q.push_back(pend);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (6) drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_vec++;
    if (box_q.size() != 0) begin
      n_err++;
      $display("FAIL box_pending: got %0d outstanding updates, expected 0", box_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
